// File: rtl/signmag_to_twos_if.sv
// Handshake bundle for the sign-magnitude to two's-complement converter.
// The master drives the operand and consumes the result; the slave is the converter.
interface signmag_to_twos_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             neg_zero;
  logic             busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, neg_zero, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, neg_zero, busy
  );
endinterface

// File: rtl/signmag_to_twos.sv
// Bit-serial sign-magnitude to two's-complement converter: the magnitude is walked
// LSB first, copying bits through the first 1 and inverting the rest when negative.
module signmag_to_twos #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  signmag_to_twos_if.slave  bus
);

  localparam int MAG_W = WIDTH - 1;
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic               seen_q, seen_d;
  logic [MAG_W-1:0]   mag_q, mag_d;
  logic [MAG_W-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               neg_zero_q, neg_zero_d;
  logic               rbit;

  // Negation rule: bits up to and including the first 1 pass, later bits flip.
  function automatic logic conv_bit(input logic sign, input logic seen, input logic b);
    return (sign & seen) ? ~b : b;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      seen_q     <= 1'b0;
      mag_q      <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      neg_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      seen_q     <= seen_d;
      mag_q      <= mag_d;
      res_q      <= res_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      neg_zero_q <= neg_zero_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    seen_d     = seen_q;
    mag_d      = mag_q;
    res_d      = res_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    neg_zero_d = neg_zero_q;
    rbit       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sign_d  = bus.in_data[WIDTH-1];
          mag_d   = bus.in_data[WIDTH-2:0];
          res_d   = '0;
          cnt_d   = '0;
          seen_d  = 1'b0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        rbit              = conv_bit(sign_q, seen_q, mag_q[0]);
        seen_d            = seen_q | mag_q[0];
        mag_d             = mag_q >> 1;
        res_d             = res_q >> 1;
        res_d[MAG_W-1]    = rbit;
        cnt_d             = cnt_q + CNT_W'(1);
        // A negative operand that never saw a 1 is negative zero: emit plain 0.
        if (cnt_q == LAST) begin
          out_data_d = {sign_q & seen_d, res_d};
          neg_zero_d = sign_q & ~seen_d;
          state_d    = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_data  = out_data_q;
  assign bus.neg_zero  = neg_zero_q;

endmodule

// File: tb/tb_signmag_to_twos.sv
// Directed and randomized checks of the serial sign-magnitude converter at
// WIDTH=32 and WIDTH=8.
module tb_signmag_to_twos;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  signmag_to_twos_if #(.WIDTH(32)) a32 ();
  signmag_to_twos_if #(.WIDTH(8))  a8 ();

  signmag_to_twos #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(a32));
  signmag_to_twos #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(a8));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model32(input logic [31:0] d);
    logic [31:0] m;
    m = {1'b0, d[30:0]};
    return d[31] ? (32'd0 - m) : m;
  endfunction

  function automatic logic [7:0] model8(input logic [7:0] d);
    logic [7:0] m;
    m = {1'b0, d[6:0]};
    return d[7] ? (8'd0 - m) : m;
  endfunction

  task automatic send32(input logic [31:0] d);
    int n = 0;
    while (a32.in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready32_before_send", {31'd0, a32.in_ready}, 32'd1);
    a32.in_valid = 1'b1;
    a32.in_data  = d;
    @(posedge clk); #1;
    a32.in_valid = 1'b0;
    a32.in_data  = 32'hDEADBEEF;
  endtask

  task automatic send8(input logic [7:0] d);
    int n = 0;
    while (a8.in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready8_before_send", {31'd0, a8.in_ready}, 32'd1);
    a8.in_valid = 1'b1;
    a8.in_data  = d;
    @(posedge clk); #1;
    a8.in_valid = 1'b0;
    a8.in_data  = 8'hA5;
  endtask

  task automatic wait_valid32(output int n);
    n = 0;
    while (a32.out_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic wait_valid8(output int n);
    n = 0;
    while (a8.out_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic conv32(input logic [31:0] d, input logic [31:0] exp, input logic nz, input string tag);
    int lat;
    send32(d);
    wait_valid32(lat);
    check({tag, "_latency"}, 32'(lat), 32'd31);
    check({tag, "_data"}, a32.out_data, exp);
    check({tag, "_negzero"}, {31'd0, a32.neg_zero}, {31'd0, nz});
    a32.out_ready = 1'b1;
    @(posedge clk); #1;
    a32.out_ready = 1'b0;
    check({tag, "_in_ready_after"}, {31'd0, a32.in_ready}, 32'd1);
  endtask

  task automatic conv8(input logic [7:0] d, input logic [7:0] exp, input logic nz, input string tag);
    int lat;
    send8(d);
    wait_valid8(lat);
    check({tag, "_latency"}, 32'(lat), 32'd7);
    check({tag, "_data"}, {24'd0, a8.out_data}, {24'd0, exp});
    check({tag, "_negzero"}, {31'd0, a8.neg_zero}, {31'd0, nz});
    a8.out_ready = 1'b1;
    @(posedge clk); #1;
    a8.out_ready = 1'b0;
    check({tag, "_in_ready_after"}, {31'd0, a8.in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] d32;
    logic [7:0]  d8;
    int          lat;
    int          n;
    logic        r;

    // Reset with a word offered: it must not be taken.
    rst = 1'b1;
    a32.in_valid = 1'b1; a32.in_data = 32'h80000005; a32.out_ready = 1'b0;
    a8.in_valid  = 1'b1; a8.in_data  = 8'h85;        a8.out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, a32.busy}, 32'd0);
    check("rst_in_ready", {31'd0, a32.in_ready}, 32'd1);
    a32.in_valid = 1'b0;
    a8.in_valid  = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_out_valid", {31'd0, a32.out_valid}, 32'd0);
    check("rst_out_data", a32.out_data, 32'd0);
    check("rst_neg_zero", {31'd0, a32.neg_zero}, 32'd0);
    check("rst_busy8", {31'd0, a8.busy}, 32'd0);

    // Directed conversions, WIDTH=32.
    conv32(32'h00000005, 32'h00000005, 1'b0, "pos5");
    conv32(32'h80000005, 32'hFFFFFFFB, 1'b0, "neg5");
    conv32(32'hFFFFFFFF, 32'h80000001, 1'b0, "negmax");
    conv32(32'h80000001, 32'hFFFFFFFF, 1'b0, "neg1");
    conv32(32'h80000000, 32'h00000000, 1'b1, "negzero");
    conv32(32'h00000000, 32'h00000000, 1'b0, "poszero");
    conv32(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, "posmax");

    // Directed conversions, WIDTH=8.
    conv8(8'h85, 8'hFB, 1'b0, "w8_neg5");
    conv8(8'h80, 8'h00, 1'b1, "w8_negzero");
    conv8(8'hFF, 8'h81, 1'b0, "w8_negmax");
    conv8(8'h7F, 8'h7F, 1'b0, "w8_posmax");

    // Backpressure: result held for 10 cycles while in_valid pulses are ignored.
    send32(32'h80000003);
    wait_valid32(lat);
    check("bp_latency", 32'(lat), 32'd31);
    for (int i = 0; i < 10; i++) begin
      a32.in_valid = (i % 2 == 0);
      a32.in_data  = 32'h00000077;
      @(posedge clk); #1;
      check("bp_out_valid", {31'd0, a32.out_valid}, 32'd1);
      check("bp_out_data", a32.out_data, 32'hFFFFFFFD);
      check("bp_neg_zero", {31'd0, a32.neg_zero}, 32'd0);
      check("bp_in_ready", {31'd0, a32.in_ready}, 32'd0);
    end
    a32.in_valid  = 1'b0;
    a32.out_ready = 1'b1;
    @(posedge clk); #1;
    a32.out_ready = 1'b0;
    check("bp_release_in_ready", {31'd0, a32.in_ready}, 32'd1);
    check("bp_release_out_valid", {31'd0, a32.out_valid}, 32'd0);
    check("bp_release_data_kept", a32.out_data, 32'hFFFFFFFD);
    @(posedge clk); #1;
    check("bp_pulses_not_latched", {31'd0, a32.busy}, 32'd0);

    // Reset while bit 12 of the magnitude is being processed.
    send32(32'h92345678);
    repeat (12) @(posedge clk);
    #1;
    check("mid_busy", {31'd0, a32.busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_in_ready", {31'd0, a32.in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, a32.out_valid}, 32'd0);
    check("mid_rst_out_data", a32.out_data, 32'd0);
    check("mid_rst_busy", {31'd0, a32.busy}, 32'd0);
    check("mid_rst_neg_zero", {31'd0, a32.neg_zero}, 32'd0);
    conv32(32'h8000000A, 32'hFFFFFFF6, 1'b0, "post_rst");

    // Random words with random out_ready, WIDTH=32.
    for (int i = 0; i < 500; i++) begin
      d32 = $urandom;
      if (i % 50 == 0) d32 = d32 & 32'h80000000;
      send32(d32);
      wait_valid32(lat);
      check("r32_latency", 32'(lat), 32'd31);
      check("r32_data", a32.out_data, model32(d32));
      check("r32_negzero", {31'd0, a32.neg_zero}, {31'd0, d32[31] && (d32[30:0] == 31'd0)});
      n = 0;
      do begin
        r = (n >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
        a32.out_ready = r;
        @(posedge clk); #1;
        n++;
        if (!r) check("r32_hold", a32.out_data, model32(d32));
      end while (!r);
      a32.out_ready = 1'b0;
      check("r32_in_ready", {31'd0, a32.in_ready}, 32'd1);
    end

    // Random words with random out_ready, WIDTH=8.
    for (int i = 0; i < 500; i++) begin
      d8 = 8'($urandom);
      if (i % 25 == 0) d8 = d8 & 8'h80;
      send8(d8);
      wait_valid8(lat);
      check("r8_latency", 32'(lat), 32'd7);
      check("r8_data", {24'd0, a8.out_data}, {24'd0, model8(d8)});
      check("r8_negzero", {31'd0, a8.neg_zero}, {31'd0, d8[7] && (d8[6:0] == 7'd0)});
      n = 0;
      do begin
        r = (n >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
        a8.out_ready = r;
        @(posedge clk); #1;
        n++;
      end while (!r);
      a8.out_ready = 1'b0;
      check("r8_in_ready", {31'd0, a8.in_ready}, 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/signmag_to_twos.md
# signmag_to_twos

Bit-serial converter from sign-magnitude to two's-complement, the decode direction of the datapath's combinational negator. It accepts one WIDTH-bit sign-magnitude word over a valid/ready handshake and forms the two's-complement value serially, LSB first, using the "copy through first 1, invert the rest" rule. It presents the result on a valid/ready output port. It sits between sign-magnitude sources (operand/display paths) and the two's-complement ALU.

## Interface
- WIDTH, 32, total word width; bit WIDTH-1 is the sign, bits WIDTH-2:0 are the magnitude (WIDTH >= 2)

- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a word; equals (state == IDLE)
- in_data  input  WIDTH  sign-magnitude operand
- out_valid  output  1  out_data/neg_zero are valid; equals (state == DONE)
- out_ready  input  1  consumer accepts the result
- out_data  output  WIDTH  two's-complement result
- neg_zero  output  1  input was negative zero (sign=1, magnitude=0)
- busy  output  1  state != IDLE

## Operation
- States: IDLE, SHIFT, DONE. On reset: state=IDLE, out_data=0, neg_zero=0, internal shift/count/seen_one registers=0. Because rst is synchronous, in_ready reads 1 only once the state is IDLE, and any input presented while rst=1 is ignored.
- IDLE: on in_valid & in_ready, latch sign=in_data[WIDTH-1] and mag=in_data[WIDTH-2:0] into the shift register, clear seen_one and count, then go to SHIFT.
- SHIFT: one magnitude bit per cycle, LSB first. With b the current LSB:
  - if sign=0 or seen_one=0, the result bit is b;
  - otherwise the result bit is ~b;
  - then seen_one |= b.
  - Result bits shift in from the MSB side of a (WIDTH-1)-bit result register.
  - After WIDTH-1 bits: out_data = {sign & seen_one, result}, neg_zero = sign & ~seen_one, then go to DONE.
- DONE: hold out_data and neg_zero stable. On out_ready, go to IDLE. out_data and neg_zero keep their values until the next DONE load.
- Arithmetic: every sign-magnitude value in ±(2^(WIDTH-1)-1) is representable, so there is no overflow output. Negative zero maps to 0 with neg_zero=1. Positive zero maps to 0 with neg_zero=0.
- in_valid while busy is ignored; the input is not latched.
- rst in any state aborts the conversion, returns to IDLE, and clears the outputs. No partial result is emitted.
- No word overlap: a new input is accepted only in IDLE.

## Timing
- Accept at edge k. SHIFT processes bits at edges k+1 .. k+WIDTH-1. out_valid rises after edge k+WIDTH-1, giving a latency of WIDTH-1 cycles (31 for the default).
- Minimum period between accepts is WIDTH+1 cycles: 1 IDLE + WIDTH-1 SHIFT + 1 DONE.
- Handshake completion:
  - The output transfer completes on the edge where out_valid & out_ready are both 1.
  - in_ready rises on the following cycle.
  - out_ready held high continuously gives the minimum period.
- All outputs are registered or decoded directly from the state register. There is no combinational path from in_* or out_ready to any output.

## Test plan
- Positive: in_data=0x00000005 -> out_valid 31 cycles after accept, out_data=0x00000005, neg_zero=0.
- Negative: in_data=0x80000005 -> out_data=0xFFFFFFFB. Also 0xFFFFFFFF -> 0x80000001, and 0x80000001 -> 0xFFFFFFFF.
- Zeros: 0x80000000 -> out_data=0x00000000 with neg_zero=1. 0x00000000 -> 0x00000000 with neg_zero=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid, out_data and neg_zero stay stable. Pulses on in_valid during this time are ignored (in_ready=0). After out_ready=1, in_ready rises the next cycle.
- Reset mid-operation: assert rst at SHIFT bit 12 -> next cycle state=IDLE, out_valid=0, out_data=0, busy=0. A following word 0x8000000A converts cleanly to 0xFFFFFFF6.
- Random: 1000 random words, including WIDTH=8 parameterization, with randomized out_ready. Compare against a model: sign ? -mag : mag, with negative zero mapping to 0 and asserting neg_zero.
